// File: rtl/uart_packet_control_pkg.sv
// Shared types and constants for the UART packet command controller.
package uart_packet_control_pkg;

  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Destination;
    logic [7:0] Source;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;

  localparam logic [7:0] CMD_RD_LEN = 8'd1;
  localparam logic [7:0] CMD_WR_LEN = 8'd5;
  localparam logic [7:0] RSP_LEN    = 8'd5;

  typedef logic [2:0] CTRL_STATE;
  localparam CTRL_STATE StIdle    = 3'd0;
  localparam CTRL_STATE StRecv    = 3'd1;
  localparam CTRL_STATE StDiscard = 3'd2;
  localparam CTRL_STATE StExec    = 3'd3;
  localparam CTRL_STATE StSend    = 3'd4;

  function automatic logic cmd_len_ok(input logic [7:0] len);
    return (len == CMD_RD_LEN) || (len == CMD_WR_LEN);
  endfunction

endpackage

// File: rtl/uart_packet_control_tx_sequencer.sv
// Response path: presents a latched 5-byte payload on the Tx stream one byte at a time,
// advancing only on cycles where the packetiser accepts the current byte.
module packet_tx_sequencer
  import uart_packet_control_pkg::*;
#(
  parameter logic [7:0] LOCAL_ADDR = 8'h7A
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [39:0] payload_i,
  input  logic [7:0]  dest_i,
  input  logic        tx_ready_i,
  output UART_PACKET  tx_o,
  output logic        done_o
);

  localparam logic [2:0] LastIdx = 3'(RSP_LEN - 8'd1);

  logic        valid_q;
  logic [2:0]  idx_q;
  logic [39:0] payload_q;
  logic [7:0]  dest_q;
  logic [7:0]  byte_sel;
  logic        live;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      idx_q     <= '0;
      payload_q <= '0;
      dest_q    <= '0;
    end else if (start_i) begin
      valid_q   <= 1'b1;
      idx_q     <= '0;
      payload_q <= payload_i;
      dest_q    <= dest_i;
    end else if (valid_q && tx_ready_i) begin
      if (idx_q == LastIdx) begin
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    byte_sel = payload_q[7:0];
      3'd1:    byte_sel = payload_q[15:8];
      3'd2:    byte_sel = payload_q[23:16];
      3'd3:    byte_sel = payload_q[31:24];
      default: byte_sel = payload_q[39:32];
    endcase
  end

  // Gating with reset lets Valid fall in the very cycle reset is applied.
  assign live = valid_q && !rst_i;

  always_comb begin
    tx_o = '0;
    if (live) begin
      tx_o.Valid       = 1'b1;
      tx_o.SoP         = (idx_q == 3'd0);
      tx_o.EoP         = (idx_q == LastIdx);
      tx_o.Destination = dest_q;
      tx_o.Source      = LOCAL_ADDR;
      tx_o.Length      = RSP_LEN;
      tx_o.Data        = byte_sel;
    end
  end

  assign done_o = live && tx_ready_i && (idx_q == LastIdx);

endmodule

// File: rtl/uart_packet_control.sv
// Decodes received read/write packets for this node, drives the register bus and
// returns a 5-byte response packet through the Tx sequencer.
module uart_packet_control
  import uart_packet_control_pkg::*;
#(
  parameter logic [7:0]  LOCAL_ADDR = 8'h7A,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  UART_PACKET  ipRxStream,
  output UART_PACKET  opTxStream,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  output logic        opRdEnable,
  input  logic [31:0] ipRdData,
  output logic [7:0]  opDropCount
);

  CTRL_STATE   state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  wait_q, wait_d;
  logic [7:0]  address_q, address_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [7:0]  drop_q, drop_d;

  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;
  logic        take_sop;
  logic        rx_sop;
  logic [31:0] shifted;
  logic        tx_start;
  logic        tx_done;
  logic [31:0] rsp_data;

  assign rx_sop  = ipRxStream.Valid && ipRxStream.SoP;
  assign shifted = {ipRxStream.Data, data_q[31:8]};

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    wait_d    = wait_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    drop_inc  = 2'd0;
    take_sop  = 1'b0;
    tx_start  = 1'b0;

    unique case (state_q)
      StIdle, StDiscard: begin
        if (rx_sop) begin
          take_sop = 1'b1;
        end else if (ipRxStream.Valid && ipRxStream.EoP) begin
          state_d = StIdle;
        end
      end
      StRecv: begin
        if (ipRxStream.Valid) begin
          if (ipRxStream.SoP) begin
            drop_inc = 2'd1;
            take_sop = 1'b1;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            data_d = shifted;
            if (ipRxStream.EoP) begin
              if (cnt_q + 8'd1 == len_q) begin
                state_d   = StExec;
                wait_d    = '0;
                address_d = addr_q;
                wr_en_d   = (len_q == CMD_WR_LEN);
                rd_en_d   = (len_q == CMD_RD_LEN);
                if (len_q == CMD_WR_LEN) wr_data_d = shifted;
              end else begin
                drop_inc = 2'd1;
                state_d  = StIdle;
              end
            end
          end
        end
      end
      StExec: begin
        if (rx_sop) drop_inc = 2'd1;
        if (len_q == CMD_WR_LEN || wait_q == 2'(RD_LATENCY)) begin
          tx_start = 1'b1;
          state_d  = StSend;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StSend: begin
        if (rx_sop) drop_inc = 2'd1;
        if (tx_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new SoP is judged on its header alone, whatever state it interrupts.
    if (take_sop) begin
      if (ipRxStream.Destination == LOCAL_ADDR && cmd_len_ok(ipRxStream.Length)) begin
        src_d  = ipRxStream.Source;
        addr_d = ipRxStream.Data;
        len_d  = ipRxStream.Length;
        cnt_d  = 8'd1;
        data_d = '0;
        if (!ipRxStream.EoP) begin
          state_d = StRecv;
        end else if (ipRxStream.Length == CMD_RD_LEN) begin
          state_d   = StExec;
          wait_d    = '0;
          address_d = ipRxStream.Data;
          rd_en_d   = 1'b1;
        end else begin
          drop_inc = drop_inc + 2'd1;
          state_d  = StIdle;
        end
      end else begin
        drop_inc = drop_inc + 2'd1;
        state_d  = ipRxStream.EoP ? StIdle : StDiscard;
      end
    end
  end

  assign drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q   <= StIdle;
      src_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      wait_q    <= '0;
      address_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      wait_q    <= wait_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      drop_q    <= drop_d;
    end
  end

  assign rsp_data = (len_q == CMD_WR_LEN) ? wr_data_q : ipRdData;

  packet_tx_sequencer #(
    .LOCAL_ADDR(LOCAL_ADDR)
  ) u_tx_seq (
    .clk_i     (ipClk),
    .rst_i     (ipReset),
    .start_i   (tx_start),
    .payload_i ({rsp_data, address_q}),
    .dest_i    (src_q),
    .tx_ready_i(ipTxReady),
    .tx_o      (opTxStream),
    .done_o    (tx_done)
  );

  assign opAddress   = address_q;
  assign opWrData    = wr_data_q;
  assign opWrEnable  = wr_en_q;
  assign opRdEnable  = rd_en_q;
  assign opDropCount = drop_q;

endmodule

// File: tb/tb_uart_packet_control.sv
// Scoreboard bench: stimulus pushes expected strobes and Tx bytes; a monitor pops and compares.
module tb_uart_packet_control;
  import uart_packet_control_pkg::*;

  localparam logic [7:0] LOCAL = 8'h7A;

  logic        ipClk = 1'b0;
  logic        ipReset;
  UART_PACKET  ipRxStream;
  UART_PACKET  opTxStream;
  logic        ipTxReady;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic        opRdEnable;
  logic [31:0] ipRdData;
  logic [7:0]  opDropCount;

  always #5 ipClk = ~ipClk;

  uart_packet_control #(
    .LOCAL_ADDR(8'h7A),
    .RD_LATENCY(1)
  ) dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipRxStream (ipRxStream),
    .opTxStream (opTxStream),
    .ipTxReady  (ipTxReady),
    .opAddress  (opAddress),
    .opWrData   (opWrData),
    .opWrEnable (opWrEnable),
    .opRdEnable (opRdEnable),
    .ipRdData   (ipRdData),
    .opDropCount(opDropCount)
  );

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] dest;
    logic [7:0] src;
    logic [7:0] len;
    logic [7:0] data;
  } tx_exp_t;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_exp_t;

  tx_exp_t     tx_q[$];
  cmd_exp_t    cmd_q[$];
  int          total = 0;
  int          bad = 0;
  int          xfers = 0;
  int          ready_mode = 0;
  int          rdy_cyc = 0;
  logic        gap_en = 1'b0;
  int          ref_drops = 0;
  logic [31:0] bank[256];
  logic [31:0] ref_mem[256];
  logic [7:0]  pkt_b[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic tx_exp_t cur_tx();
    return tx_exp_t'({opTxStream.SoP, opTxStream.EoP, opTxStream.Destination,
                      opTxStream.Source, opTxStream.Length, opTxStream.Data});
  endfunction

  // Packetiser ready: always, 1-in-4, or random.
  initial begin
    ipTxReady = 1'b1;
    forever begin
      @(posedge ipClk);
      #1;
      rdy_cyc++;
      case (ready_mode)
        0:       ipTxReady = 1'b1;
        1:       ipTxReady = (rdy_cyc % 4 == 0);
        default: ipTxReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Register bank with one cycle of read latency.
  initial begin
    logic       rd;
    logic [7:0] ra;
    ipRdData = '0;
    forever begin
      @(negedge ipClk);
      rd = opRdEnable;
      ra = opAddress;
      if (opWrEnable) bank[opAddress] = opWrData;
      @(posedge ipClk);
      #1;
      if (rd) ipRdData = bank[ra];
    end
  end

  // Monitor.
  initial begin
    tx_exp_t  e;
    tx_exp_t  held;
    cmd_exp_t c;
    logic     pend;
    pend = 1'b0;
    forever begin
      @(negedge ipClk);
      if (ipReset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("tx_hold", {opTxStream.Valid, cur_tx()}, {1'b1, held});
          pend = 1'b0;
        end
        if (opWrEnable || opRdEnable) begin
          if (cmd_q.size() == 0) begin
            chk("unexpected_strobe", 64'(cmd_q.size()), 64'd1);
          end else begin
            c = cmd_q.pop_front();
            chk("strobe_kind", {opWrEnable, opRdEnable}, {c.wr, !c.wr});
            chk("strobe_addr", opAddress, c.addr);
            if (c.wr) chk("wr_data", opWrData, c.data);
          end
        end
        if (opTxStream.Valid) begin
          if (ipTxReady) begin
            xfers++;
            if (tx_q.size() == 0) begin
              chk("unexpected_tx", 64'(tx_q.size()), 64'd1);
            end else begin
              e = tx_q.pop_front();
              chk("tx_byte", cur_tx(), e);
            end
          end else begin
            pend = 1'b1;
            held = cur_tx();
          end
        end
      end
    end
  end

  // Reference model: a packet is a command only if it is complete, addressed here, and its
  // byte count equals a legal Length; anything else costs exactly one drop.
  task automatic model_pkt(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] len,
                           input int n, input logic complete);
    logic [31:0] d;
    logic [7:0]  a;
    logic [39:0] rsp;
    if (complete && dest == LOCAL && ((len == 8'd1 && n == 1) || (len == 8'd5 && n == 5))) begin
      a = pkt_b[0];
      if (len == 8'd5) begin
        d = {pkt_b[4], pkt_b[3], pkt_b[2], pkt_b[1]};
        ref_mem[a] = d;
        cmd_q.push_back(cmd_exp_t'({1'b1, a, d}));
      end else begin
        d = ref_mem[a];
        cmd_q.push_back(cmd_exp_t'({1'b0, a, 32'h0}));
      end
      rsp = {d, a};
      for (int i = 0; i < 5; i++)
        tx_q.push_back(tx_exp_t'({i == 0, i == 4, src, LOCAL, 8'd5, rsp[8*i +: 8]}));
    end else if (ref_drops < 255) begin
      ref_drops++;
    end
  endtask

  task automatic send_pkt(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] len,
                          input int n, input logic with_eop);
    for (int i = 0; i < n; i++) begin
      if (gap_en && i > 0 && $urandom_range(0, 2) == 0) begin
        ipRxStream.Valid = 1'b0;
        @(posedge ipClk);
        #1;
      end
      ipRxStream.Valid       = 1'b1;
      ipRxStream.SoP         = (i == 0);
      ipRxStream.EoP         = with_eop && (i == n - 1);
      ipRxStream.Destination = dest;
      ipRxStream.Source      = src;
      ipRxStream.Length      = len;
      ipRxStream.Data        = pkt_b[i];
      @(posedge ipClk);
      #1;
    end
    ipRxStream = '0;
  endtask

  task automatic issue(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] len,
                       input int n);
    model_pkt(dest, src, len, n, 1'b1);
    send_pkt(dest, src, len, n, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((tx_q.size() != 0 || cmd_q.size() != 0) && k < 300) begin
      @(posedge ipClk);
      #1;
      k++;
    end
    chk({name, "_outstanding"}, 64'(tx_q.size() + cmd_q.size()), 64'd0);
  endtask

  task automatic fill(input logic [7:0] b0, input logic [31:0] d);
    pkt_b[0] = b0;
    pkt_b[1] = d[7:0];
    pkt_b[2] = d[15:8];
    pkt_b[3] = d[23:16];
    pkt_b[4] = d[31:24];
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  dest, len;
    int          n, kind, x0, k;

    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      bank[i] = v;
      ref_mem[i] = v;
    end
    bank[8'h10] = 32'h1234_5678;
    ref_mem[8'h10] = 32'h1234_5678;

    ipRxStream = '0;
    ipReset = 1'b1;
    repeat (3) @(posedge ipClk);
    @(negedge ipClk);
    chk("rst_tx_valid", opTxStream.Valid, 1'b0);
    chk("rst_tx_fields", opTxStream, '0);
    chk("rst_drop", opDropCount, 8'd0);
    chk("rst_strobes", {opWrEnable, opRdEnable}, 2'b00);
    chk("rst_addr_data", {opAddress, opWrData}, 40'd0);
    @(posedge ipClk);
    #1;
    ipReset = 1'b0;

    // Read of a preloaded register.
    fill(8'h10, 32'h0);
    issue(LOCAL, 8'h2C, 8'd1, 1);
    wait_done("read");

    // Write with the response-latency check.
    fill(8'h10, 32'hDEAD_BEEF);
    issue(LOCAL, 8'h2C, 8'd5, 5);
    @(negedge ipClk);
    chk("wr_lat_cycle1", opTxStream.Valid, 1'b0);
    @(negedge ipClk);
    chk("wr_lat_cycle2", opTxStream.Valid, 1'b1);
    wait_done("write");
    chk("drop_after_cmds", opDropCount, 8'(ref_drops));

    // Backpressure: 1 high / 3 low.
    ready_mode = 1;
    fill(8'h33, 32'hA5C3_0F96);
    issue(LOCAL, 8'h41, 8'd5, 5);
    wait_done("backpressure");
    ready_mode = 0;

    // Filtering.
    fill(8'h20, 32'h0);
    issue(8'h55, 8'h2C, 8'd1, 1);
    chk("drop_wrong_dest", opDropCount, 8'(ref_drops));
    issue(LOCAL, 8'h2C, 8'd3, 3);
    chk("drop_bad_len", opDropCount, 8'(ref_drops));
    fill(8'h33, 32'h0);
    issue(LOCAL, 8'h2C, 8'd1, 1);
    wait_done("filter_read");

    // Write truncated after 2 bytes, then a read right behind it.
    fill(8'h44, 32'h1111_2222);
    model_pkt(LOCAL, 8'h2C, 8'd5, 2, 1'b0);
    send_pkt(LOCAL, 8'h2C, 8'd5, 2, 1'b0);
    fill(8'h10, 32'h0);
    issue(LOCAL, 8'h2C, 8'd1, 1);
    wait_done("midsop_read");
    chk("drop_midsop", opDropCount, 8'(ref_drops));

    // A packet arriving while a response is being sent is dropped.
    ready_mode = 1;
    fill(8'h55, 32'h0BAD_F00D);
    issue(LOCAL, 8'h2C, 8'd5, 5);
    repeat (3) begin
      @(posedge ipClk);
      #1;
    end
    fill(8'h66, 32'h7777_7777);
    ref_drops++;
    send_pkt(LOCAL, 8'h2C, 8'd5, 5, 1'b1);
    wait_done("busy_drop");
    chk("drop_busy", opDropCount, 8'(ref_drops));
    ready_mode = 0;

    // Reset after two response bytes have gone.
    fill(8'h77, 32'hCAFE_0001);
    x0 = xfers;
    issue(LOCAL, 8'h2C, 8'd5, 5);
    k = 0;
    while (xfers < x0 + 2 && k < 100) begin
      @(posedge ipClk);
      #1;
      k++;
    end
    chk("rst_send_reached", 64'(xfers - x0), 64'd2);
    ipReset = 1'b1;
    tx_q.delete();
    cmd_q.delete();
    ref_drops = 0;
    @(negedge ipClk);
    chk("rst_send_valid_now", opTxStream.Valid, 1'b0);
    @(posedge ipClk);
    #1;
    ipReset = 1'b0;
    @(negedge ipClk);
    chk("rst_send_valid_after", opTxStream.Valid, 1'b0);
    chk("rst_send_drop", opDropCount, 8'd0);
    @(posedge ipClk);
    #1;
    fill(8'h77, 32'h0);
    issue(LOCAL, 8'h2C, 8'd1, 1);
    wait_done("post_rst_read");

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      ready_mode = $urandom_range(0, 2);
      gap_en = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) pkt_b[i] = 8'($urandom);
      case (kind)
        0: issue(LOCAL, 8'($urandom), 8'd5, 5);
        1: issue(LOCAL, 8'($urandom), 8'd1, 1);
        2: begin
          dest = 8'($urandom);
          if (dest == LOCAL) dest = 8'h7B;
          len = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd5;
          issue(dest, 8'($urandom), len, int'(len));
        end
        3: begin
          len = 8'($urandom_range(0, 7));
          n = $urandom_range(1, 6);
          if ((len == 8'd1 && n == 1) || (len == 8'd5 && n == 5)) n = n + 1;
          issue(LOCAL, 8'($urandom), len, n);
        end
        default: begin
          n = $urandom_range(1, 4);
          model_pkt(LOCAL, 8'h2C, 8'd5, n, 1'b0);
          send_pkt(LOCAL, 8'h2C, 8'd5, n, 1'b0);
          for (int i = 0; i < 8; i++) pkt_b[i] = 8'($urandom);
          issue(LOCAL, 8'($urandom), 8'd1, 1);
        end
      endcase
      wait_done("rand");
      chk("rand_drop", opDropCount, 8'(ref_drops));
    end

    repeat (5) @(posedge ipClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_packet_control.md
Name: uart_packet_control

Overview:
- Command controller between the `UART_Packets` packetiser and a 256 x 32-bit register bank.
- Consumes received packets (`UART_PACKET` stream) addressed to this node and decodes each as a register read or register write.
- Drives the register bus for each accepted command, then sequences a 5-byte response packet back into the packetiser Tx stream, observing its ready handshake.

Parameters:
- LOCAL_ADDR, 8'h7A, node address; packets with any other Destination are discarded.
- RD_LATENCY, 1, cycles from opRdEnable to valid ipRdData (1..3).

Ports:
- ipClk  in  1  system clock
- ipReset  in  1  synchronous active-high reset
- ipRxStream  in  UART_PACKET  received bytes from packetiser
- opTxStream  out  UART_PACKET  response bytes to packetiser
- ipTxReady  in  1  packetiser can accept a Tx byte
- opAddress  out  8  register address
- opWrData  out  32  register write data
- opWrEnable  out  1  one-cycle write strobe
- opRdEnable  out  1  one-cycle read strobe
- ipRdData  in  32  register read data, valid RD_LATENCY cycles after opRdEnable
- opDropCount  out  8  saturating count of discarded packets

Behaviour:
- One clock, ipClk. Synchronous active-high reset ipReset.
- Reset values: state IDLE; all opTxStream fields 0 (Valid=0); opAddress, opWrData, opWrEnable, opRdEnable = 0; opDropCount = 0.
- Reset mid-packet or mid-send aborts immediately. Tx Valid drops in the same cycle reset is sampled.
- Rx format: one Valid pulse per payload byte. SoP marks the first byte, EoP the last. Destination, Source and Length are stable while Valid is high.
- Command decode:
  - Length=1: read. Byte0 = address.
  - Length=5: write. Byte0 = address, bytes1..4 = data, least-significant byte first.
- States:
  - IDLE: wait for Valid&SoP. If Destination==LOCAL_ADDR and Length is 1 or 5, capture Source and byte0, set byte counter to 1, go to RECV. Otherwise go to DISCARD.
  - RECV: each Valid byte is shifted into the data register and increments the counter.
    - On EoP with counter+1==Length: go to EXEC.
    - On EoP with a count mismatch: drop, go to IDLE.
    - On a new SoP: drop the current packet and re-evaluate the new one as in IDLE, in the same cycle.
  - DISCARD: ignore bytes until EoP, then go to IDLE. A new SoP is re-evaluated.
  - EXEC:
    - Write: pulse opWrEnable for 1 cycle, latch opWrData as the response data, go to SEND.
    - Read: pulse opRdEnable, wait RD_LATENCY cycles, latch ipRdData, go to SEND.
    - opAddress holds the captured address from EXEC entry until return to IDLE.
  - SEND: present 5 bytes in order: address, data[7:0], [15:8], [23:16], [31:24].
    - Header fields: Destination = captured Source, Source = LOCAL_ADDR, Length = 5.
    - SoP is set on byte 0 only, EoP on byte 4 only.
    - A byte transfers on the edge where Valid && ipTxReady are both high. The next byte is presented on the following cycle.
    - Valid deasserts after byte 4 transfers; go to IDLE.
- Rx activity during EXEC or SEND: the packet is discarded and counted. Its remaining bytes are ignored until EoP.
- Drops: every discarded packet increments opDropCount once, at its SoP or at detection of mismatch. The counter saturates at 8'hFF.
- Back-to-back operation: a SoP arriving in the same cycle the controller returns to IDLE is accepted.
- Latency, write with ipTxReady high: first Tx Valid 2 cycles after the EoP byte.

Decomposition:
- Structures package:
  - `UART_PACKET` struct: Valid, SoP, EoP, Destination[7:0], Source[7:0], Length[7:0], Data[7:0].
  - Command-length constants `CMD_RD_LEN`=1, `CMD_WR_LEN`=5, `RSP_LEN`=5.
  - State enum `CTRL_STATE`.
- One natural sub-module: `packet_tx_sequencer`. It takes a 40-bit response payload and header fields, and runs the SEND byte/handshake loop.

Test Plan:
- Write: Dest 7A, Src 2C, Len 5, bytes 10,EF,BE,AD,DE → one opWrEnable pulse with opAddress=10, opWrData=DEADBEEF; Tx packet Dest 2C, Src 7A, Len 5, bytes 10,EF,BE,AD,DE, SoP on first, EoP on last.
- Read: Dest 7A, Src 2C, Len 1, byte 10, register model returns 12345678 after 1 cycle → Tx bytes 10,78,56,34,12.
- Backpressure: ipTxReady toggles 1 cycle high / 3 low during a response → each byte held stable until accepted, no duplicate or lost bytes, EoP only on byte 5.
- Filtering:
  - Dest 55 → no register strobe, no Tx, opDropCount=1.
  - Then Len 3 to 7A → opDropCount=2.
  - Then a valid read → normal response.
- Mid-packet SoP: write truncated after 2 bytes, followed by a new valid read → no opWrEnable, read served, opDropCount=1.
- Reset during SEND after 2 bytes → Tx Valid=0 the cycle after reset; the next valid command is served normally.
